mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_pkg.sv | 26 ++
 rtl/mdu_calc.sv | 51 +++++
 rtl/mdu_ctrl.sv | 86 ++++++++
 tb/tb_mdu_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared MDU op encodings, default latencies and op-class helpers
package mdu_pkg;

   localparam logic [3:0] OP_NONE  = 4'd0;
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Multi-cycle ops: the ones that occupy the unit and raise busy
   function automatic logic is_muldiv(input logic [3:0] op);
      return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational multiply/divide datapath producing HI/LO results
module mdu_calc
   import mdu_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi_next,
   output logic [31:0] o_lo_next,
   output logic        o_div0
);

   logic signed [63:0] w_a_s, w_b_s, w_prod_s;
   logic        [63:0] w_prod_u;
   logic        [31:0] w_den_s, w_den_u;
   logic signed [31:0] w_quo_s, w_rem_s;
   logic        [31:0] w_quo_u, w_rem_u;
   logic               w_b_zero, w_div_ovf;

   assign w_a_s    = {{32{i_a[31]}}, i_a};
   assign w_b_s    = {{32{i_b[31]}}, i_b};
   assign w_prod_s = w_a_s * w_b_s;
   assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

   // A zero divisor is replaced by 1 so the divider never sees it; the result is discarded anyway.
   // INT_MIN / -1 also uses divisor 1: quotient INT_MIN, remainder 0 is the wrapped answer.
   assign w_b_zero  = (i_b == 32'd0);
   assign w_div_ovf = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);
   assign w_den_s   = (w_b_zero || w_div_ovf) ? 32'd1 : i_b;
   assign w_den_u   = w_b_zero ? 32'd1 : i_b;

   assign w_quo_s = $signed(i_a) / $signed(w_den_s);
   assign w_rem_s = $signed(i_a) % $signed(w_den_s);
   assign w_quo_u = i_a / w_den_u;
   assign w_rem_u = i_a % w_den_u;

   // Select the result pair for the requested op; non-arithmetic ops yield zeros
   always_comb begin
      o_hi_next = 32'd0;
      o_lo_next = 32'd0;
      o_div0    = 1'b0;
      case (i_op)
         OP_MULT:  begin o_hi_next = w_prod_s[63:32]; o_lo_next = w_prod_s[31:0]; end
         OP_MULTU: begin o_hi_next = w_prod_u[63:32]; o_lo_next = w_prod_u[31:0]; end
         OP_DIV:   begin o_hi_next = w_rem_s; o_lo_next = w_quo_s; o_div0 = w_b_zero; end
         OP_DIVU:  begin o_hi_next = w_rem_u; o_lo_next = w_quo_u; o_div0 = w_b_zero; end
         default:  begin o_hi_next = 32'd0; o_lo_next = 32'd0; end
      endcase
   end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MDU controller: busy counter, HI/LO registers, read mux and stall request
module mdu_ctrl
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        E_MDU_start,
   input  logic [3:0]  E_MDUop,
   input  logic [31:0] E_MDU_A,
   input  logic [31:0] E_MDU_B,
   input  logic        D_MDU_use,
   output logic        E_MDU_busy,
   output logic [31:0] E_MDU_out,
   output logic        D_stall_MDU
);

   localparam logic [3:0] L_MULT_CNT = 4'(MULT_CYCLES);
   localparam logic [3:0] L_DIV_CNT  = 4'(DIV_CYCLES);

   logic [31:0] r_hi, r_lo, r_a, r_b;
   logic [3:0]  r_op, r_cnt;
   logic        r_busy;
   logic [31:0] w_hi_next, w_lo_next;
   logic        w_div0;

   // The result is computed from the latched operands and only committed when the count expires
   mdu_calc u_calc (
      .i_op      (r_op),
      .i_a       (r_a),
      .i_b       (r_b),
      .o_hi_next (w_hi_next),
      .o_lo_next (w_lo_next),
      .o_div0    (w_div0)
   );

   // Busy countdown, HI/LO commit on expiry, and start/move handling while idle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hi   <= 32'd0;
         r_lo   <= 32'd0;
         r_a    <= 32'd0;
         r_b    <= 32'd0;
         r_op   <= OP_NONE;
         r_cnt  <= 4'd0;
         r_busy <= 1'b0;
      end else if (r_busy) begin
         r_cnt <= r_cnt - 4'd1;
         if (r_cnt == 4'd1) begin
            r_busy <= 1'b0;
            if (!w_div0) begin
               r_hi <= w_hi_next;
               r_lo <= w_lo_next;
            end
         end
      end else if (E_MDU_start) begin
         if (is_muldiv(E_MDUop)) begin
            r_op   <= E_MDUop;
            r_a    <= E_MDU_A;
            r_b    <= E_MDU_B;
            r_cnt  <= is_div(E_MDUop) ? L_DIV_CNT : L_MULT_CNT;
            r_busy <= 1'b1;
         end else if (E_MDUop == OP_MTHI) begin
            r_hi <= E_MDU_A;
         end else if (E_MDUop == OP_MTLO) begin
            r_lo <= E_MDU_A;
         end
      end
   end

   // Read port for MFHI/MFLO; every other code reads zero
   always_comb begin
      E_MDU_out = 32'd0;
      if (E_MDUop == OP_MFHI)
         E_MDU_out = r_hi;
      else if (E_MDUop == OP_MFLO)
         E_MDU_out = r_lo;
   end

   assign E_MDU_busy  = r_busy;
   assign D_stall_MDU = D_MDU_use & (r_busy | (E_MDU_start & is_muldiv(E_MDUop)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with directed and random stimulus
module tb_mdu_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        E_MDU_start;
   logic [3:0]  E_MDUop;
   logic [31:0] E_MDU_A, E_MDU_B;
   logic        D_MDU_use;
   logic        E_MDU_busy;
   logic [31:0] E_MDU_out;
   logic        D_stall_MDU;

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk         (clk),
      .reset       (reset),
      .E_MDU_start (E_MDU_start),
      .E_MDUop     (E_MDUop),
      .E_MDU_A     (E_MDU_A),
      .E_MDU_B     (E_MDU_B),
      .D_MDU_use   (D_MDU_use),
      .E_MDU_busy  (E_MDU_busy),
      .E_MDU_out   (E_MDU_out),
      .D_stall_MDU (D_stall_MDU)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference state: architectural HI/LO plus one pending result with its completion edge
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
   bit          pend = 1'b0, p_div0 = 1'b0;
   int          cyc = 0, done_at = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output bit div0);
      longint sa, sb, p, q, r;
      logic [63:0] pu;
      hi = 32'd0; lo = 32'd0; div0 = 1'b0;
      case (op)
         4'd1: begin
            p  = longint'($signed(a)) * longint'($signed(b));
            hi = p[63:32]; lo = p[31:0];
         end
         4'd2: begin
            pu = {32'd0, a} * {32'd0, b};
            hi = pu[63:32]; lo = pu[31:0];
         end
         4'd3, 4'd4: begin
            if (b == 32'd0) div0 = 1'b1;
            else begin
               sa = (op == 4'd3) ? longint'($signed(a)) : longint'({32'd0, a});
               sb = (op == 4'd3) ? longint'($signed(b)) : longint'({32'd0, b});
               q  = sa / sb;
               r  = sa % sb;
               hi = r[31:0]; lo = q[31:0];
            end
         end
         default: ;
      endcase
   endtask

   task automatic model_edge(input bit rst, input bit st, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
      if (rst) begin
         m_hi = 32'd0; m_lo = 32'd0; pend = 1'b0;
      end else if (pend) begin
         if (cyc == done_at) begin
            pend = 1'b0;
            if (!p_div0) begin m_hi = p_hi; m_lo = p_lo; end
         end
      end else if (st) begin
         if (op >= 4'd1 && op <= 4'd4) begin
            model_compute(op, a, b, p_hi, p_lo, p_div0);
            pend    = 1'b1;
            done_at = cyc + ((op >= 4'd3) ? DC : MC);
         end else if (op == 4'd7) m_hi = a;
         else if (op == 4'd8) m_lo = a;
      end
      cyc++;
   endtask

   // drive one cycle of inputs, check combinational outputs against the model, then clock
   task automatic step(input bit rst, input bit st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input bit use_d);
      logic [31:0] exp_out;
      bit          exp_stall;
      reset = rst; E_MDU_start = st; E_MDUop = op; E_MDU_A = a; E_MDU_B = b; D_MDU_use = use_d;
      #1;
      exp_out   = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
      exp_stall = use_d & (pend | (st & (op >= 4'd1) & (op <= 4'd4)));
      check("busy",  {31'd0, E_MDU_busy},  {31'd0, pend});
      check("stall", {31'd0, D_stall_MDU}, {31'd0, exp_stall});
      check("out",   E_MDU_out, exp_out);
      @(posedge clk);
      model_edge(rst, st, op, a, b);
      #1;
   endtask

   task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
      reset = 1'b0; E_MDU_start = 1'b0; D_MDU_use = 1'b0;
      E_MDUop = 4'd5; #1; check({tag, "_hi"}, E_MDU_out, hi);
      E_MDUop = 4'd6; #1; check({tag, "_lo"}, E_MDU_out, lo);
   endtask

   task automatic busy_len(input string tag, input int exp_n);
      int n = 0;
      while (E_MDU_busy === 1'b1 && n < 20) begin
         n++;
         step(0, 0, 4'd0, 32'd0, 32'd0, 0);
      end
      check(tag, 32'(n), 32'(exp_n));
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      reset = 1'b1; E_MDU_start = 1'b0; E_MDUop = 4'd0;
      E_MDU_A = 32'd0; E_MDU_B = 32'd0; D_MDU_use = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      step(1, 1, 4'd1, 32'd3, 32'd3, 1);
      check_hilo("rst", 32'd0, 32'd0);
      check("rst_busy", {31'd0, E_MDU_busy}, 32'd0);

      step(0, 1, 4'd1, 32'hFFFF_FFFF, 32'd2, 0);
      busy_len("mult_len", MC);
      check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      step(0, 1, 4'd2, 32'hFFFF_FFFF, 32'd2, 0);
      busy_len("multu_len", MC);
      check_hilo("multu", 32'd1, 32'hFFFF_FFFE);

      step(0, 1, 4'd4, 32'd7, 32'd2, 0);
      busy_len("divu_len", DC);
      check_hilo("divu", 32'd1, 32'd3);

      step(0, 1, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
      busy_len("div_len", DC);
      check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      step(0, 1, 4'd7, 32'h1234_5678, 32'd0, 0);
      step(0, 1, 4'd3, 32'd55, 32'd0, 0);
      busy_len("div0_len", DC);
      check_hilo("div0", 32'h1234_5678, 32'hFFFF_FFFD);

      E_MDU_start = 1'b1; E_MDUop = 4'd3; D_MDU_use = 1'b1; #1;
      check("stall_start", {31'd0, D_stall_MDU}, 32'd1);
      step(0, 1, 4'd3, 32'd100, 32'd7, 1);
      for (int i = 0; i < 12; i++) begin
         E_MDU_start = (i == 4); E_MDUop = 4'd1; D_MDU_use = 1'b1; #1;
         check("stall_hold", {31'd0, D_stall_MDU}, (i < 10) ? 32'd1 : 32'd0);
         step(0, i == 4, 4'd1, 32'd5, 32'd5, 1);
      end
      check_hilo("div_ign", 32'd2, 32'd14);

      step(0, 1, 4'd1, 32'd3, 32'd4, 0);
      step(0, 0, 4'd0, 32'd0, 32'd0, 0);
      step(0, 0, 4'd0, 32'd0, 32'd0, 0);
      step(1, 0, 4'd0, 32'd0, 32'd0, 0);
      check("abort_busy", {31'd0, E_MDU_busy}, 32'd0);
      check_hilo("abort", 32'd0, 32'd0);
      repeat (5) step(0, 0, 4'd0, 32'd0, 32'd0, 0);
      check_hilo("abort_late", 32'd0, 32'd0);

      repeat (800) begin
         logic [3:0] op;
         op = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
         step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, op,
              rnd_val(), rnd_val(), $urandom_range(0, 1) == 1);
      end
      repeat (DC + 1) step(0, 0, 4'd0, 32'd0, 32'd0, 0);
      check_hilo("final", m_hi, m_lo);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
